example_text_fetch_unit: RTL and testbench

Instruction-fetch initiator that drives the program text memory bus. It owns the fetch PC, issues one word-address per cycle, and captures the combinational read_data into a small prefetch FIFO. It presents fetched words to the core decode stage through a valid/ready handshake. It accepts PC redirects (branch/jump/trap) from the core, which flush all in-flight words.

---
 rtl/example_fetch_pkg.sv | 25 ++
 rtl/rv_config.sv | 8 +
 rtl/example_fetch_fifo.sv | 68 ++++++
 rtl/example_text_fetch_unit.sv | 120 ++++++++++++
 tb/tb_example_text_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/example_fetch_pkg.sv
// Shared types and helpers for the text fetch unit and its prefetch FIFO.
package example_fetch_pkg;

  localparam logic [31:0] TEXT_BEGIN     = rv_config::TEXT_BEGIN;
  localparam logic [31:0] TEXT_END       = rv_config::TEXT_END;
  // Highest address at which a whole 4-byte word still lies inside the text segment.
  localparam logic [31:0] TEXT_LAST_WORD = TEXT_END - 32'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  // A fetch address faults when misaligned or when its word leaves the text segment.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_BEGIN) || (pc > TEXT_LAST_WORD);
  endfunction

endpackage

// File: rtl/rv_config.sv
// Platform memory-map constants shared by the RISC-V blocks.
// TEXT_END is the last byte address (inclusive) of the program text segment.
package rv_config;

  localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TEXT_END   = 32'h0FFF_FFFF;

endpackage

// File: rtl/example_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries. Flush wins over push/pop.
// Storage resets to zero so an empty FIFO presents an all-zero head.
module example_fetch_fifo
  import example_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = pop & ~empty;
  // Pushing into a full FIFO is only allowed when the head leaves on the same edge.
  assign w_do_push = push & (~full | w_do_pop);

  assign full  = (r_count == DEPTH_C);
  assign empty = (r_count == {CW{1'b0}});
  assign head  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wr_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/example_text_fetch_unit.sv
// Instruction-fetch initiator: owns the fetch PC, reads one word per cycle from
// the text bus into a prefetch FIFO and hands words to decode via valid/ready.
// Optional performance counters are enabled by EXAMPLE_TEXT_FETCH_STATS_EN.
module example_text_fetch_unit
  import example_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = rv_config::TEXT_BEGIN,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  logic [31:0]  r_fetch_pc;
  fetch_state_t r_state;

  logic         w_fault;
  logic         w_pop;
  logic         w_push;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  assign w_fault = pc_fault(r_fetch_pc);
  assign w_pop   = ~w_empty & inst_ready;
  assign w_push  = (r_state == FETCH) & (~w_full | w_pop) & ~redirect_valid;

  // A faulting fetch never forwards bus data to the core.
  assign w_entry.pc    = r_fetch_pc;
  assign w_entry.data  = w_fault ? 32'h0000_0000 : bus_read_data;
  assign w_entry.fault = w_fault;

  example_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .wr_entry (w_entry),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  assign bus_address = r_fetch_pc;
  assign inst_valid  = ~w_empty;
  assign inst_data   = w_head.data;
  assign inst_pc     = w_head.pc;
  assign inst_fault  = w_head.fault;

  // Fetch PC and FETCH/HALT state; redirect overrides everything else.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_state    <= FETCH;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_state    <= FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_push) begin
            if (w_fault) begin
              r_state <= HALT;
            end else begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalls;

  // Free-running fetch and back-pressure counters; redirects leave them alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= 32'd0;
      r_perf_stalls  <= 32'd0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (inst_valid && !inst_ready) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_example_text_fetch_unit.sv
// Self-checking bench for example_text_fetch_unit: a constant vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_example_text_fetch_unit;

  localparam logic [31:0] TB_TEXT_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TB_TEXT_END   = 32'h0FFF_FFFF;
  localparam logic [31:0] TB_RESET_PC   = 32'h0040_0000;
  localparam int          TB_DEPTH      = 4;
  localparam logic [31:0] KEY           = 32'h5A5A_5A5A;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] bus_address;
  logic [31:0] bus_read_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  always #5 clock = ~clock;

  // Text memory: every word is its own address scrambled with a key.
  assign bus_read_data = bus_address ^ KEY;

  example_text_fetch_unit #(
    .RESET_PC   (TB_RESET_PC),
    .FIFO_DEPTH (TB_DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .bus_address    (bus_address),
    .bus_read_data  (bus_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_halt;
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
  logic [31:0] m_fetched;
  logic [31:0] m_stalls;
`endif

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_bus;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A word is usable only if aligned and all four bytes lie in [TEXT_BEGIN, TEXT_END].
  function automatic logic m_is_fault(input logic [31:0] pc);
    logic [32:0] last_byte;
    last_byte = {1'b0, pc} + 33'd3;
    return (pc % 32'd4 != 32'd0) || (pc < TB_TEXT_BEGIN) || (last_byte > {1'b0, TB_TEXT_END});
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = TB_RESET_PC;
    m_halt = 1'b0;
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
    m_fetched = 32'd0;
    m_stalls  = 32'd0;
`endif
  endtask

  // Apply inputs for one cycle and compare DUT outputs with the model mid-cycle.
  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy);
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clock);
    chk("valid", 32'(inst_valid), 32'(mq.size() != 0));
    chk("bus_address", bus_address, m_pc);
    if (mq.size() != 0) begin
      chk("head_pc", inst_pc, mq[0].pc);
      chk("head_data", inst_data, mq[0].data);
      chk("head_fault", 32'(inst_fault), 32'(mq[0].fault));
    end
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  // Advance the model by one clock edge, then move to just after that edge.
  task automatic step();
    logic pop;
    logic push;
    logic f;
    ent_t e;
    pop  = (mq.size() != 0) && inst_ready;
    push = !m_halt && ((mq.size() < TB_DEPTH) || pop) && !redirect_valid;
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
    if ((mq.size() != 0) && !inst_ready) m_stalls = m_stalls + 32'd1;
    if (push) m_fetched = m_fetched + 32'd1;
`endif
    if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_pc;
      m_halt = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        f       = m_is_fault(m_pc);
        e.pc    = m_pc;
        e.data  = f ? 32'h0 : (m_pc ^ KEY);
        e.fault = f;
        mq.push_back(e);
        if (f) m_halt = 1'b1;
        else   m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic redir, input logic [31:0] rpc, input logic rdy);
    drive(redir, rpc, rdy);
    step();
  endtask

  // Hold reset over an edge, then release just after the next edge.
  task automatic do_reset(input logic rdy);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = rdy;
    reset_n        = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic redir, input logic [31:0] rpc,
                         input logic ev, input logic [31:0] epc, input logic [31:0] ebus,
                         input logic ef);
    tbl[i].redir     = redir;
    tbl[i].rpc       = rpc;
    tbl[i].rdy       = 1'b1;
    tbl[i].exp_valid = ev;
    tbl[i].exp_pc    = epc;
    tbl[i].exp_bus   = ebus;
    tbl[i].exp_fault = ef;
  endtask

  initial begin
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;

    // Reset release streaming, last-word fault and misaligned-redirect sequences.
    set_vec( 0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0000, 1'b0);
    set_vec( 1, 1'b0, 32'h0,         1'b1, 32'h0040_0000, 32'h0040_0004, 1'b0);
    set_vec( 2, 1'b0, 32'h0,         1'b1, 32'h0040_0004, 32'h0040_0008, 1'b0);
    set_vec( 3, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 32'h0040_000C, 1'b0);
    set_vec( 4, 1'b0, 32'h0,         1'b1, 32'h0040_000C, 32'h0040_0010, 1'b0);
    set_vec( 5, 1'b1, 32'h0FFF_FFFC, 1'b1, 32'h0040_0010, 32'h0040_0014, 1'b0);
    set_vec( 6, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0FFF_FFFC, 1'b0);
    set_vec( 7, 1'b0, 32'h0,         1'b1, 32'h0FFF_FFFC, 32'h1000_0000, 1'b0);
    set_vec( 8, 1'b0, 32'h0,         1'b1, 32'h1000_0000, 32'h1000_0000, 1'b1);
    set_vec( 9, 1'b0, 32'h0,         1'b0, 32'h0,         32'h1000_0000, 1'b0);
    set_vec(10, 1'b0, 32'h0,         1'b0, 32'h0,         32'h1000_0000, 1'b0);
    set_vec(11, 1'b1, 32'h0040_0102, 1'b0, 32'h0,         32'h1000_0000, 1'b0);
    set_vec(12, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0102, 1'b0);
    set_vec(13, 1'b0, 32'h0,         1'b1, 32'h0040_0102, 32'h0040_0102, 1'b1);
    set_vec(14, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0102, 1'b0);
    set_vec(15, 1'b1, 32'h0040_0200, 1'b0, 32'h0,         32'h0040_0102, 1'b0);
    set_vec(16, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0200, 1'b0);
    set_vec(17, 1'b0, 32'h0,         1'b1, 32'h0040_0200, 32'h0040_0204, 1'b0);
    set_vec(18, 1'b0, 32'h0,         1'b1, 32'h0040_0204, 32'h0040_0208, 1'b0);

    // Reset values while reset is held.
    #1;
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_fault", 32'(inst_fault), 32'h0);
    chk("rst_bus", bus_address, TB_RESET_PC);
    do_reset(1'b1);

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].exp_valid));
      chk("tbl_bus", bus_address, tbl[i].exp_bus);
      if (tbl[i].exp_valid) begin
        chk("tbl_pc", inst_pc, tbl[i].exp_pc);
        chk("tbl_fault", 32'(inst_fault), 32'(tbl[i].exp_fault));
        chk("tbl_data", inst_data, tbl[i].exp_fault ? 32'h0 : (tbl[i].exp_pc ^ KEY));
      end
      step();
    end

    // Back-pressure: fill, freeze, then drain in order.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b0);
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
      if (i == 4) chk("stalls_3", perf_stalls, 32'd3);
`endif
      step();
    end
    drive(1'b0, 32'h0, 1'b1);
    chk("freeze_bus", bus_address, 32'h0040_0010);
    step();
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("drain_pc", inst_pc, 32'h0040_0000 + 32'(4 * i));
      step();
    end

    // Redirect while full.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h0040_0100, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_gap", 32'(inst_valid), 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_head", inst_pc, 32'h0040_0100);
    step();
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b1);

    // Randomized traffic against the model.
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       rpc = 32'h0040_0000 + 32'(4 * $urandom_range(0, 63));
        1:       rpc = 32'h0FFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        2:       rpc = 32'h1000_0000;
        3:       rpc = 32'h003F_FFFC;
        4:       rpc = 32'h0040_0000 + 32'($urandom_range(0, 255));
        5:       rpc = 32'h0FFF_FFFD;
        6:       rpc = 32'hFFFF_FFFC;
        default: rpc = 32'h0040_0100;
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      cyc(redir, rpc, rdy);
    end

    // Asynchronous reset mid-stream with a full FIFO.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0);
    chk("full_before_reset", 32'(inst_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(inst_valid), 32'h0);
    chk("async_pc", inst_pc, 32'h0);
    chk("async_data", inst_data, 32'h0);
    chk("async_bus", bus_address, TB_RESET_PC);
`ifdef EXAMPLE_TEXT_FETCH_STATS_EN
    chk("async_stalls", perf_stalls, 32'h0);
`endif
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
